// File: rtl/mips_datapath_state_if.sv
// mips_datapath_state_if
//   Bundles the datapath back-end signals between the control/ALU side
//   (master) and the stateful back-end (slave).
//   ALU decode : alu_op, funct -> c_line
//   Reg file   : ra1, ra2 -> rd1, rd2 ; reg_we, wa, wd ; wa_q (debug)
//   Data memory: mem_r, mem_w, addr, mem_wd -> mem_rd
//   Observation: d11..d33 = memory words 0..8, row-major
interface mips_datapath_state_if;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [3:0]  c_line;

    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        reg_we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] wa_q;

    logic        mem_r;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] d11, d12, d13;
    logic [31:0] d21, d22, d23;
    logic [31:0] d31, d32, d33;

    modport master (
        output alu_op, funct,
        output ra1, ra2, reg_we, wa, wd,
        output mem_r, mem_w, addr, mem_wd,
        input  c_line, rd1, rd2, wa_q, mem_rd,
        input  d11, d12, d13, d21, d22, d23, d31, d32, d33
    );

    modport slave (
        input  alu_op, funct,
        input  ra1, ra2, reg_we, wa, wd,
        input  mem_r, mem_w, addr, mem_wd,
        output c_line, rd1, rd2, wa_q, mem_rd,
        output d11, d12, d13, d21, d22, d23, d31, d32, d33
    );
endinterface

// File: rtl/mips_datapath_state.sv
// mips_datapath_state
//   Stateful back-end of the single-cycle MIPS datapath plus ALU control
//   decode: 32x32 register file, 64-word data memory, and the ALUOp/funct
//   to 4-bit ALU control translation. Memory words 0..8 are exposed as a
//   3x3 matrix for observation.
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset, clears registers and memory
//   bus  - mips_datapath_state_if.slave (see interface for signal list)
module mips_datapath_state (
    input  logic                        clk,
    input  logic                        rst,
    mips_datapath_state_if.slave        bus
);

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    logic [3:0] c_line;

    always_comb begin
        c_line = ALU_INVALID;
        unique case (bus.alu_op)
            2'b00: c_line = ALU_ADD;
            2'b01: c_line = ALU_SUB;
            2'b11: c_line = ALU_OR;
            2'b10: begin
                case (bus.funct)
                    6'b100000: c_line = ALU_ADD;
                    6'b100010: c_line = ALU_SUB;
                    6'b100100: c_line = ALU_AND;
                    6'b100101: c_line = ALU_OR;
                    6'b101010: c_line = ALU_SLT;
                    6'b100111: c_line = ALU_NOR;
                    default:   c_line = ALU_INVALID;
                endcase
            end
            default: c_line = ALU_INVALID;
        endcase
    end

    assign bus.c_line = c_line;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] regs [32];
    logic        reg_wr_en;

    // R0 is hardwired to zero, so writes addressed to it are dropped.
    assign reg_wr_en = bus.reg_we && (bus.wa != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_wr_en) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    // No bypass: a write in flight is only visible after its edge.
    assign bus.rd1  = (bus.ra1 == 5'd0) ? 32'd0 : regs[bus.ra1];
    assign bus.rd2  = (bus.ra2 == 5'd0) ? 32'd0 : regs[bus.ra2];
    assign bus.wa_q = (bus.wa  == 5'd0) ? 32'd0 : regs[bus.wa];

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [31:0] mem [64];
    logic [5:0]  mem_idx;
    logic        mem_in_range;
    logic        mem_wr_en;

    // Word addressed; the byte offset bits are ignored and anything at or
    // above byte 0x100 falls outside the 64-word array.
    assign mem_idx      = bus.addr[7:2];
    assign mem_in_range = (bus.addr[31:8] == 24'd0);
    assign mem_wr_en    = bus.mem_w && mem_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_wr_en) begin
            mem[mem_idx] <= bus.mem_wd;
        end
    end

    // Read is combinational, so with mem_r and mem_w both high the old
    // word is returned until the write commits at the edge.
    assign bus.mem_rd = (bus.mem_r && mem_in_range) ? mem[mem_idx] : 32'd0;

    assign bus.d11 = mem[0];
    assign bus.d12 = mem[1];
    assign bus.d13 = mem[2];
    assign bus.d21 = mem[3];
    assign bus.d22 = mem[4];
    assign bus.d23 = mem[5];
    assign bus.d31 = mem[6];
    assign bus.d32 = mem[7];
    assign bus.d33 = mem[8];

endmodule

// File: tb/tb_mips_datapath_state.sv
module tb_mips_datapath_state;

    logic clk;
    logic rst;

    mips_datapath_state_if bus ();

    mips_datapath_state dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output selectors for the scoreboard
    localparam int S_CLINE = 0;
    localparam int S_RD1   = 1;
    localparam int S_RD2   = 2;
    localparam int S_WAQ   = 3;
    localparam int S_MEMRD = 4;
    localparam int S_D11   = 5;   // S_D11 + k  ->  memory word k, k = 0..8

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [31:0] get_out(int sel);
        case (sel)
            S_CLINE:   return {28'd0, bus.c_line};
            S_RD1:     return bus.rd1;
            S_RD2:     return bus.rd2;
            S_WAQ:     return bus.wa_q;
            S_MEMRD:   return bus.mem_rd;
            S_D11 + 0: return bus.d11;
            S_D11 + 1: return bus.d12;
            S_D11 + 2: return bus.d13;
            S_D11 + 3: return bus.d21;
            S_D11 + 4: return bus.d22;
            S_D11 + 5: return bus.d23;
            S_D11 + 6: return bus.d31;
            S_D11 + 7: return bus.d32;
            S_D11 + 8: return bus.d33;
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: combinational outputs are presented mid-cycle; every
    // pending expectation is compared at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = get_out(e.sel);
            n_checks++;
            if (act === e.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic expect_out(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after a rising edge; the monitor samples
    // at the following falling edge, before the next write edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_matrix(input string name, input logic [31:0] v [9]);
        for (int k = 0; k < 9; k++) begin
            expect_out($sformatf("%s_d%0d%0d", name, k / 3 + 1, k % 3 + 1), S_D11 + k, v[k]);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] exp;
    } alu_vec_t;

    alu_vec_t alu_tab [10] = '{
        '{2'b00, 6'h00, 4'b0010},
        '{2'b01, 6'h00, 4'b0110},
        '{2'b11, 6'h00, 4'b0001},
        '{2'b10, 6'h20, 4'b0010},
        '{2'b10, 6'h22, 4'b0110},
        '{2'b10, 6'h24, 4'b0000},
        '{2'b10, 6'h25, 4'b0001},
        '{2'b10, 6'h2A, 4'b0111},
        '{2'b10, 6'h27, 4'b1100},
        '{2'b10, 6'h00, 4'b1111}
    };

    logic [31:0] mat [9];

    initial begin
        rst        = 1'b1;
        bus.alu_op = 2'b00;
        bus.funct  = 6'h00;
        bus.ra1    = 5'd3;
        bus.ra2    = 5'd17;
        bus.reg_we = 1'b0;
        bus.wa     = 5'd9;
        bus.wd     = 32'd0;
        bus.mem_r  = 1'b1;
        bus.mem_w  = 1'b0;
        bus.addr   = 32'h10;
        bus.mem_wd = 32'd0;

        // Reset
        repeat (3) step();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) mat[k] = 32'd0;
        expect_out("rst_rd1", S_RD1, 32'd0);
        expect_out("rst_rd2", S_RD2, 32'd0);
        expect_out("rst_waq", S_WAQ, 32'd0);
        expect_out("rst_memrd", S_MEMRD, 32'd0);
        expect_matrix("rst", mat);
        step();

        // ALU control decode
        foreach (alu_tab[i]) begin
            bus.alu_op = alu_tab[i].op;
            bus.funct  = alu_tab[i].fn;
            expect_out($sformatf("alu_op%0b_fn%02h", alu_tab[i].op, alu_tab[i].fn),
                       S_CLINE, {28'd0, alu_tab[i].exp});
            step();
        end

        // Register file: R5 write, no bypass before the edge
        bus.mem_r  = 1'b0;
        bus.ra1    = 5'd5;
        bus.wa     = 5'd5;
        bus.wd     = 32'hDEAD_BEEF;
        bus.reg_we = 1'b1;
        expect_out("reg_pre_rd1", S_RD1, 32'd0);
        expect_out("reg_pre_waq", S_WAQ, 32'd0);
        step();
        bus.reg_we = 1'b0;
        expect_out("reg_r5_rd1", S_RD1, 32'hDEAD_BEEF);
        expect_out("reg_r5_waq", S_WAQ, 32'hDEAD_BEEF);
        step();

        // R0 write discarded
        bus.wa     = 5'd0;
        bus.wd     = 32'h0000_1234;
        bus.reg_we = 1'b1;
        step();
        bus.reg_we = 1'b0;
        bus.ra2    = 5'd0;
        expect_out("reg_r0_rd2", S_RD2, 32'd0);
        expect_out("reg_r0_waq", S_WAQ, 32'd0);
        step();

        // R31 via rd2, R5 untouched
        bus.wa     = 5'd31;
        bus.wd     = 32'h8000_0001;
        bus.reg_we = 1'b1;
        step();
        bus.reg_we = 1'b0;
        bus.ra2    = 5'd31;
        expect_out("reg_r31_rd2", S_RD2, 32'h8000_0001);
        expect_out("reg_r5_keep", S_RD1, 32'hDEAD_BEEF);
        step();

        // Memory matrix fill
        for (int k = 0; k < 9; k++) begin
            bus.mem_w  = 1'b1;
            bus.addr   = 32'(4 * k);
            bus.mem_wd = 32'(k + 1);
            step();
        end
        bus.mem_w = 1'b0;
        for (int k = 0; k < 9; k++) mat[k] = 32'(k + 1);
        expect_matrix("fill", mat);
        bus.mem_r = 1'b1;
        bus.addr  = 32'h10;
        expect_out("load_0x10", S_MEMRD, 32'd5);
        step();
        bus.mem_r = 1'b0;
        expect_out("load_nord", S_MEMRD, 32'd0);
        step();

        // Top word
        bus.mem_w  = 1'b1;
        bus.addr   = 32'hFC;
        bus.mem_wd = 32'hAAAA_0063;
        step();
        bus.mem_w = 1'b0;
        bus.mem_r = 1'b1;
        expect_out("load_0xfc", S_MEMRD, 32'hAAAA_0063);
        step();

        // Out of range store and load (would alias word 0 if not decoded)
        bus.mem_r  = 1'b0;
        bus.mem_w  = 1'b1;
        bus.addr   = 32'h100;
        bus.mem_wd = 32'h0000_0BAD;
        step();
        bus.mem_w = 1'b0;
        bus.mem_r = 1'b1;
        expect_out("load_0x100", S_MEMRD, 32'd0);
        expect_matrix("oor", mat);
        step();
        bus.addr = 32'h0;
        expect_out("load_0x00", S_MEMRD, 32'd1);
        step();
        bus.addr = 32'hFC;
        expect_out("load_0xfc_keep", S_MEMRD, 32'hAAAA_0063);
        step();

        // Unaligned store lands on word 1
        bus.mem_r  = 1'b0;
        bus.mem_w  = 1'b1;
        bus.addr   = 32'h05;
        bus.mem_wd = 32'h77;
        step();
        bus.mem_w = 1'b0;
        mat[1]    = 32'h77;
        expect_out("st_0x05_d12", S_D11 + 1, 32'h77);
        expect_out("st_0x05_d11", S_D11 + 0, 32'd1);
        step();

        // Read and write same word in one cycle: old data returned
        bus.mem_r  = 1'b1;
        bus.mem_w  = 1'b1;
        bus.addr   = 32'h08;
        bus.mem_wd = 32'h99;
        expect_out("rw_old", S_MEMRD, 32'd3);
        step();
        bus.mem_w = 1'b0;
        mat[2]    = 32'h99;
        expect_out("rw_new", S_MEMRD, 32'h99);
        step();

        // Simultaneous register and memory write
        bus.mem_r  = 1'b0;
        bus.reg_we = 1'b1;
        bus.wa     = 5'd7;
        bus.wd     = 32'h0000_7777;
        bus.mem_w  = 1'b1;
        bus.addr   = 32'h20;
        bus.mem_wd = 32'h0000_1111;
        step();
        bus.reg_we = 1'b0;
        bus.mem_w  = 1'b0;
        mat[8]     = 32'h0000_1111;
        expect_out("dual_waq", S_WAQ, 32'h0000_7777);
        expect_matrix("dual", mat);
        step();

        // Async reset mid-cycle with writes requested across the next edge
        rst        = 1'b1;
        bus.ra1    = 5'd5;
        bus.ra2    = 5'd31;
        bus.reg_we = 1'b1;
        bus.wa     = 5'd5;
        bus.wd     = 32'h5555_AAAA;
        bus.mem_w  = 1'b1;
        bus.mem_r  = 1'b1;
        bus.addr   = 32'h10;
        bus.mem_wd = 32'h4444_4444;
        for (int k = 0; k < 9; k++) mat[k] = 32'd0;
        expect_out("arst_rd1", S_RD1, 32'd0);
        expect_out("arst_rd2", S_RD2, 32'd0);
        expect_out("arst_waq", S_WAQ, 32'd0);
        expect_out("arst_memrd", S_MEMRD, 32'd0);
        expect_matrix("arst", mat);
        step();
        rst        = 1'b0;
        bus.reg_we = 1'b0;
        bus.mem_w  = 1'b0;
        expect_out("post_rst_waq", S_WAQ, 32'd0);
        expect_out("post_rst_memrd", S_MEMRD, 32'd0);
        expect_matrix("post_rst", mat);
        step();

        // First write after reset release
        bus.reg_we = 1'b1;
        bus.wa     = 5'd9;
        bus.wd     = 32'h0000_0099;
        step();
        bus.reg_we = 1'b0;
        expect_out("post_rst_wr", S_WAQ, 32'h0000_0099);
        step();

        // Drain scoreboard, bounded
        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 0 && guard < 20) begin
                step();
                guard++;
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_datapath_state.md
# mips_datapath_state

Stateful back-end and ALU decode of the single-cycle MIPS datapath: a 32×32 register file, a 64-word data memory, and the combinational ALU control decoder. It sits downstream of the instruction decode/control unit and around the ALU. It supplies register operands, performs loads and stores, and translates ALUOp/funct into the 4-bit ALU control line. Nine memory words are exposed continuously as a 3×3 matrix for observation.

## Interface
Parameters:
- none (widths fixed: 32-bit data, 5-bit register index, 64-word memory)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_op  in  2  ALUOp from control unit
- funct  in  6  instruction[5:0]
- c_line  out  4  ALU control line
- ra1  in  5  register read address 1 (rs)
- ra2  in  5  register read address 2 (rt)
- rd1  out  32  register read data 1
- rd2  out  32  register read data 2
- reg_we  in  1  register write enable
- wa  in  5  register write address
- wd  in  32  register write data
- wa_q  out  32  current contents of register wa (debug port)
- mem_r  in  1  memory read enable
- mem_w  in  1  memory write enable
- addr  in  32  memory byte address (ALU result)
- mem_wd  in  32  memory write data (rt value)
- mem_rd  out  32  memory read data
- d11,d12,d13,d21,d22,d23,d31,d32,d33  out  32 each  memory words 0..8, row-major

## Operation
- ALU control (purely combinational):
  - alu_op 00 -> 0010 (add, lw/sw)
  - alu_op 01 -> 0110 (sub, beq)
  - alu_op 11 -> 0001 (or, ori)
  - alu_op 10 decodes funct:
    - 100000 -> 0010 (add)
    - 100010 -> 0110 (sub)
    - 100100 -> 0000 (and)
    - 100101 -> 0001 (or)
    - 101010 -> 0111 (slt)
    - 100111 -> 1100 (nor)
    - any other funct -> 1111 (invalid)
- Register file:
  - rd1 = R[ra1], rd2 = R[ra2], wa_q = R[wa], all combinational.
  - R0 always reads 0; writes to R0 are discarded.
  - No write-through bypass.
- Data memory:
  - Word index = addr[7:2]. addr[1:0] is ignored.
  - If addr[31:8] ≠ 0, the access is out of range: writes are ignored and mem_rd = 0.
  - mem_rd = M[index] when mem_r = 1 and in range, else 0.
  - Store occurs when mem_w = 1 and in range.
  - mem_r and mem_w both high: the read returns the old word this cycle and the write commits at the edge.
  - dNM = M[3·(N−1)+(M−1)], combinational, independent of mem_r.

## Timing
- Writes are synchronous on the rising edge of clk. Reads and c_line are combinational with zero latency.
- Register write: R[wa] <= wd at the edge when reg_we = 1 and wa ≠ 0. The new value is visible on rd1/rd2/wa_q after that edge.
- Memory write: M[index] <= mem_wd at the edge when mem_w = 1 and in range.
- Reset (rst = 1, asynchronous, takes effect immediately and overrides the clock):
  - All 32 registers and all 64 memory words become 0.
  - After reset: rd1, rd2, wa_q, mem_rd and d11..d33 = 0. c_line still follows its inputs.
- Writes are blocked for the whole time rst is high. The first write can occur on the first rising edge after rst falls.
- Reset asserted mid-operation discards any pending write on that edge.
- Simultaneous register write and memory write in one cycle are independent and both commit.

## Test plan
- Reset: hold rst = 1, then release -> rd1 = rd2 = wa_q = mem_rd = 0 and d11..d33 = 0 for any addresses.
- ALU decode:
  - sweep alu_op 00/01/11 -> 0010/0110/0001
  - alu_op 10 with funct 0x20/0x22/0x24/0x25/0x2A/0x27 -> 0010/0110/0000/0001/0111/1100
  - alu_op 10 with funct 0x00 -> 1111
- Register file: write 0xDEADBEEF to R5, then ra1 = 5 -> rd1 = 0xDEADBEEF. Write 0x1234 to R0 -> rd2 with ra2 = 0 reads 0. rd1 does not change before the write edge.
- Memory matrix: store values 1..9 at addr 0x00, 0x04, …, 0x20 -> d11 = 1, d12 = 2 … d33 = 9. Load with mem_r = 1 at addr 0x10 -> mem_rd = 5. With mem_r = 0 -> mem_rd = 0.
- Boundaries:
  - store at addr 0xFC -> word 63 is written
  - store at addr 0x100 -> no change anywhere
  - load at addr 0x100 -> 0
  - store at addr 0x05 -> word 1 is written
- Async reset mid-run: after writes, pulse rst between clock edges -> all outputs are 0 immediately. A write request present on the next edge while rst is still high is ignored.
